// File: rtl/mul_unit_pkg.sv
// Shared types and defaults for the iterative RV32M multiplier.
// Imported by the interface, the step datapath and the mul_unit top.
package mul_unit_pkg;

  localparam int DEF_XLEN           = 32;
  localparam int DEF_BITS_PER_CYCLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// EX-stage <-> multiplier signal bundle: request/operands from EX, stall/result back.
interface mul_unit_if
  import mul_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);

  logic            i_start;
  logic            i_flush;
  logic            i_hold;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic            i_src1_signed;
  logic            i_src2_signed;
  logic            i_sel_high;
  logic            o_stall_req;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_flush, i_hold, i_src1, i_src2,
           i_src1_signed, i_src2_signed, i_sel_high,
    input  o_stall_req, o_valid, o_result
  );

  modport slave (
    input  i_start, i_flush, i_hold, i_src1, i_src2,
           i_src1_signed, i_src2_signed, i_sel_high,
    output o_stall_req, o_valid, o_result
  );

endinterface

// File: rtl/mul_unit_step.sv
// One BUSY-cycle datapath step: acc + (mcand * multiplier slice) << shift.
// Purely combinational; the caller owns all state.
module mul_unit_step
  import mul_unit_pkg::*;
#(
  parameter int XLEN           = DEF_XLEN,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE,
  parameter int SHIFT_W        = $clog2(2 * XLEN)
) (
  input  logic [2*XLEN-1:0]         acc,
  input  logic [XLEN-1:0]           mcand,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [SHIFT_W-1:0]        shift,
  output logic [2*XLEN-1:0]         acc_next
);

  logic [2*XLEN-1:0] wide_mcand;
  logic [2*XLEN-1:0] partial;

  assign wide_mcand = {{XLEN{1'b0}}, mcand};

  // NOTE: combinational logic uses blocking '=' so each loop iteration sees the
  // previous partial sum; 'partial' gets a default first so no latch is inferred.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (slice[j]) partial = partial + (wide_mcand << j);
    end
    acc_next = acc + (partial << shift);
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the EX stage.
// Multiplies operand magnitudes BITS_PER_CYCLE bits per cycle, fixes the sign at the end.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int XLEN           = DEF_XLEN,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  mul_unit_if.slave  bus
);

  localparam int N       = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W   = cnt_width(N);
  localparam int SHIFT_W = $clog2(2 * XLEN);

  mul_state_e        state;
  logic [CNT_W-1:0]  counter;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              negate_q;
  logic              sel_high_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              sign1;
  logic              sign2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [CNT_W-1:0]  step;
  logic [SHIFT_W-1:0] shift_amt;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] product;

  assign accept = (state == ST_IDLE) & bus.i_start & ~bus.i_flush;

  // Magnitudes fit in XLEN unsigned bits, including |-2^(XLEN-1)|.
  assign sign1 = bus.i_src1[XLEN-1] & bus.i_src1_signed;
  assign sign2 = bus.i_src2[XLEN-1] & bus.i_src2_signed;
  assign mag1  = sign1 ? -bus.i_src1 : bus.i_src1;
  assign mag2  = sign2 ? -bus.i_src2 : bus.i_src2;

  // Counter runs N-1 down to 0, so the step index is its complement.
  assign step      = CNT_W'(N - 1) - counter;
  assign shift_amt = SHIFT_W'(step) * SHIFT_W'(BITS_PER_CYCLE);

  mul_unit_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SHIFT_W        (SHIFT_W)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand_q),
    .slice    (mplier_q[BITS_PER_CYCLE-1:0]),
    .shift    (shift_amt),
    .acc_next (acc_next)
  );

  assign product = negate_q ? -acc_next : acc_next;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; datapath registers are reset too so outputs are clean.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      counter    <= '0;
      acc        <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      negate_q   <= 1'b0;
      sel_high_q <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
    end else if (bus.i_flush) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (bus.i_start) begin
            mcand_q    <= mag1;
            mplier_q   <= mag2;
            negate_q   <= sign1 ^ sign2;
            sel_high_q <= bus.i_sel_high;
            acc        <= '0;
            counter    <= CNT_W'(N - 1);
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc      <= acc_next;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          counter  <= counter - CNT_W'(1);
          if (counter == '0) begin
            result_q <= sel_high_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
            valid_q  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // i_start here is the same insn still in EX, so it is not re-accepted.
          if (!bus.i_hold) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Gated by reset so the pipeline is never held while the unit is in reset.
  assign bus.o_stall_req = i_rst_n & (accept | (state == ST_BUSY));
  assign bus.o_valid     = valid_q;
  assign bus.o_result    = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed, table-driven bench for mul_unit: sign/half vectors plus flush,
// hold and reset sequences with cycle-exact stall/valid expectations.
module tb_mul_unit;

  localparam int XLEN = 32;
  localparam int N    = 16;

  typedef struct {
    logic [31:0] src1;
    logic [31:0] src2;
    logic        s1;
    logic        s2;
    logic        hi;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[16];

  mul_unit_if #(.XLEN(XLEN)) bus ();

  mul_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(2)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    bus.i_src1        = v.src1;
    bus.i_src2        = v.src2;
    bus.i_src1_signed = v.s1;
    bus.i_src2_signed = v.s2;
    bus.i_sel_high    = v.hi;
  endtask

  task automatic scramble();
    bus.i_src1        = $urandom;
    bus.i_src2        = $urandom;
    bus.i_src1_signed = 1'($urandom_range(1));
    bus.i_src2_signed = 1'($urandom_range(1));
    bus.i_sel_high    = 1'($urandom_range(1));
  endtask

  // Full op: accept in cycle 0, operands scrambled afterwards, result in cycle N+1,
  // held hold_n extra cycles with i_start still high, then the insn leaves EX.
  task automatic do_op(input vec_t v, input int hold_n, input string tag);
    int stall_bad;
    int valid_bad;
    stall_bad = 0;
    valid_bad = 0;
    for (int c = 0; c <= N; c++) begin
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_flush = 1'b0;
      bus.i_hold  = 1'b0;
      if (c == 0) drive_vec(v);
      else        scramble();
      #1;
      if (bus.o_stall_req !== 1'b1) stall_bad++;
      if (bus.o_valid !== 1'b0)     valid_bad++;
    end
    check({tag, "/stall_cycles_0_to_N"}, stall_bad, 0);
    check({tag, "/valid_low_before_N+1"}, valid_bad, 0);
    for (int c = 0; c <= hold_n; c++) begin
      @(negedge clk);
      bus.i_hold = (c < hold_n);
      #1;
      check($sformatf("%s/valid_done%0d", tag, c), bus.o_valid, 1);
      check($sformatf("%s/result_done%0d", tag, c), bus.o_result, v.exp);
      check($sformatf("%s/stall_done%0d", tag, c), bus.o_stall_req, 0);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_hold  = 1'b0;
    #1;
    check({tag, "/valid_dropped"}, bus.o_valid, 0);
    check({tag, "/stall_idle"}, bus.o_stall_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int valid_seen;
    n_checks = 0;
    n_fail   = 0;

    //            src1          src2          s1    s2    hi    expected
    vecs[0]  = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b0, 32'hFFFFFFEB};
    vecs[1]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000};
    vecs[6]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 32'hC0000000};
    vecs[7]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 32'h80000000};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h80000000};
    vecs[9]  = '{32'h12345678, 32'h00000010, 1'b0, 1'b0, 1'b0, 32'h23456780};
    vecs[10] = '{32'h12345678, 32'h00000010, 1'b0, 1'b0, 1'b1, 32'h00000001};
    vecs[11] = '{32'h00000000, 32'hFFFFFFFB, 1'b1, 1'b1, 1'b1, 32'h00000000};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[13] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'hC0000000};
    vecs[14] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[15] = '{32'hFFFFFFF6, 32'h00000005, 1'b1, 1'b1, 1'b0, 32'hFFFFFFCE};

    // Reset state, with a mul insn already in EX.
    rst_n = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_hold  = 1'b0;
    bus.i_start = 1'b1;
    drive_vec(vecs[0]);
    repeat (2) @(negedge clk);
    #1;
    check("reset/stall", bus.o_stall_req, 0);
    check("reset/valid", bus.o_valid, 0);
    check("reset/result", bus.o_result, 0);
    @(negedge clk);
    bus.i_start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) do_op(vecs[i], 0, $sformatf("vec%0d", i));

    // Hold in DONE for 3 cycles: result presented 4 cycles, no re-accept.
    do_op(vecs[6], 3, "hold3");

    // Flush in BUSY cycle 5.
    @(negedge clk);
    bus.i_start = 1'b1;
    drive_vec(vecs[0]);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      scramble();
      bus.i_flush = (c == 5);
    end
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_start = 1'b0;
    #1;
    check("flush_busy/stall_next", bus.o_stall_req, 0);
    check("flush_busy/valid_next", bus.o_valid, 0);
    valid_seen = 0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.o_valid !== 1'b0 || bus.o_stall_req !== 1'b0) valid_seen++;
    end
    check("flush_busy/quiet_after", valid_seen, 0);

    // Flush together with start in IDLE: no accept.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_flush = 1'b1;
    drive_vec(vecs[1]);
    #1;
    check("flush_idle/stall", bus.o_stall_req, 0);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    valid_seen = 0;
    for (int c = 0; c < N + 4; c++) begin
      #1;
      if (bus.o_valid !== 1'b0 || bus.o_stall_req !== 1'b0) valid_seen++;
      @(negedge clk);
    end
    check("flush_idle/no_accept", valid_seen, 0);

    // Operation still works after flushes.
    do_op(vecs[15], 0, "post_flush");

    // Async reset mid-BUSY; o_result still holds the previous result until then.
    @(negedge clk);
    bus.i_start = 1'b1;
    drive_vec(vecs[2]);
    repeat (8) @(negedge clk);
    #1;
    check("pre_reset/result_held", bus.o_result, 32'hFFFFFFCE);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset/stall", bus.o_stall_req, 0);
    check("mid_reset/valid", bus.o_valid, 0);
    check("mid_reset/result", bus.o_result, 0);
    @(negedge clk);
    bus.i_start = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_reset/idle_stall", bus.o_stall_req, 0);
    do_op(vecs[8], 0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
